// File: rtl/rad_cdc_mcp_back_buf.sv
// rad_cdc_mcp_back_buf
// Destination-side (bclk) receive controller for the multi-bit MCP CDC path.
// Each synchronized enable pulse captures the held MCP data bus into a
// DEPTH-entry buffer. Words leave through a valid/ready port. One credit per
// accepted word goes back to the source on back_tgl. While the buffer is
// full, that credit is held back, so the source is paced by buffer space.
//
// Handshake: bdata is transferred on a rising bclk edge where bvalid=1 and
// bready=1. bvalid depends only on registered state and never on bready.
// bdata holds steady while bvalid=1 and bready=0.
//
// Optional build macro RAD_CDC_MCP_BACK_BUF_OVF_EN: when it is defined,
// bovf is a sticky flag that records a word dropped because the source sent
// without a credit. When it is undefined, bovf is tied low.
module rad_cdc_mcp_back_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         bclk,
  input  logic                         brst_n,
  input  logic                         b_en,
  input  logic [WIDTH-1:0]             bdata_in,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [WIDTH-1:0]             bdata,
  output logic                         back_tgl,
  output logic [$clog2(DEPTH+1)-1:0]   bcount,
  output logic                         bovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Credit state: a credit is owed when the word that filled the buffer has
  // not yet been acknowledged.
  typedef enum logic {
    ACK_CLEAR = 1'b0,
    ACK_OWED  = 1'b1
  } ack_state_e;

  ack_state_e             ack_state_q, ack_state_d;
  logic                   tgl_q, tgl_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          wp_q, wp_d;
  logic [AW-1:0]          rp_q, rp_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full;
  logic                   push;
  logic                   pop;

  // Buffer control: decide push/pop and compute the next pointers and count.
  always_comb begin
    full    = (count_q == DEPTH_C);
    pop     = (count_q != '0) && bready;
    push    = b_en && (!full || pop);
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Credit FSM next state: send an acknowledge toggle now, or hold it back
  // while the buffer is full. At most one toggle is sent per cycle.
  always_comb begin
    ack_state_d = ack_state_q;
    tgl_d       = tgl_q;
    if (push) begin
      if (count_d != DEPTH_C) begin
        tgl_d = ~tgl_q;
      end else begin
        // Buffer ends full: release any older owed credit; new one is owed.
        if (pop && (ack_state_q == ACK_OWED)) tgl_d = ~tgl_q;
        ack_state_d = ACK_OWED;
      end
    end else if (pop && (ack_state_q == ACK_OWED)) begin
      tgl_d       = ~tgl_q;
      ack_state_d = ACK_CLEAR;
    end
  end

  // Pointer, count and credit-state registers.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      tgl_q       <= 1'b0;
      ack_state_q <= ACK_CLEAR;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      tgl_q       <= tgl_d;
      ack_state_q <= ack_state_d;
    end
  end

  // Storage: capture the MCP bus into the write slot on an accepted push.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wp_q] <= bdata_in;
    end
  end

`ifdef RAD_CDC_MCP_BACK_BUF_OVF_EN
  logic ovf_q;
  logic drop;

  // A word arrives with no free slot and no pop to make room.
  assign drop = b_en && full && !pop;

  // Sticky overflow: set on a dropped word, cleared only by reset.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n)   ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign bovf = ovf_q;
`else
  assign bovf = 1'b0;
`endif

  assign bvalid   = (count_q != '0);
  assign bdata    = mem_q[rp_q];
  assign back_tgl = tgl_q;
  assign bcount   = count_q;

endmodule

// File: doc/rad_cdc_mcp_back_buf.md
Name: rad_cdc_mcp_back_buf

Overview:
Destination-side (bclk domain) receive controller for the multi-bit CDC MCP path: next generation of the single-state valid/load FSM. On each synchronized enable pulse it captures the MCP data bus into a DEPTH-entry buffer and presents words through a valid/ready interface. It returns an acknowledge toggle to the source domain, deferred when the buffer is full, so the source is throttled by buffer space, not consumer latency.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 2, buffer entries; power of two, 2..16

Ports:
bclk  input  1  destination clock
brst_n  input  1  asynchronous active-low reset
b_en  input  1  one-cycle enable pulse from pulse generator; bdata_in stable and valid this cycle
bdata_in  input  WIDTH  MCP data bus from source domain (held stable by source)
bvalid  output  1  bdata holds a valid word
bready  input  1  consumer accepts bdata this cycle when bvalid=1
bdata  output  WIDTH  head-of-buffer word
back_tgl  output  1  acknowledge toggle to source domain; each edge returns one credit
bcount  output  $clog2(DEPTH+1)  number of words held
bovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (brst_n=0, async): bvalid=0, bdata=0, back_tgl=0, bcount=0, bovf=0, pointers=0, ack_pending=0, storage=0.
- Storage: DEPTH x WIDTH registers, write pointer wp and read pointer rp, each $clog2(DEPTH) bits; pointers wrap naturally at DEPTH.
- push = b_en && (bcount<DEPTH || pop); pop = bvalid && bready.
- push: mem[wp] <= bdata_in, wp++ at the clock edge.
- pop: rp++.
- bcount updates next edge: +1 push only, -1 pop only, unchanged for both or neither.
- bvalid = (bcount!=0), registered-state derived.
- bdata = mem[rp] (combinational read of registered storage).
- Latency: b_en at cycle N into an empty buffer -> bvalid=1 and bdata=captured word at N+1.
- Ack policy; one credit is owed per accepted push:
  - push with post-update count < DEPTH -> back_tgl inverts at the same edge.
  - push with post-update count == DEPTH -> ack_pending<=1, no toggle.
  - pop while ack_pending=1 and no push in the same cycle -> back_tgl inverts, ack_pending<=0.
  - push and pop in the same cycle with count==DEPTH -> count stays DEPTH; the old pending credit is released (toggle) and the new push becomes pending. At most one toggle per cycle.
- Protocol violation: b_en when bcount==DEPTH and no pop (source sent without a credit) -> word dropped, no pointer/count/toggle change.
- b_en while ack_pending=1 and a slot is free cannot occur with a correct source; push is accepted as normal with no additional credit.
- Empty: bready ignored when bvalid=0.
- Full: bvalid stays 1 and bready pops normally.
- Reset mid-operation: all buffered words discarded and back_tgl returns to 0. The source side must be reset in the same reset domain.
- back_tgl is a flop output with no combinational path, suitable for a 2-flop synchronizer.

Optional Feature:
Macro RAD_CDC_MCP_BACK_BUF_OVF_EN.
- Defined: bovf is set to 1 on the edge after a protocol-violation b_en (dropped word) and stays set until reset.
- Undefined: no overflow logic; bovf is tied to 0 and dropped words are silent.
- Datapath and ack behaviour are identical in both cases.

Test Plan:
- Reset, then single b_en with bdata_in=0xA5, bready=0 -> bvalid=1, bdata=0xA5, bcount=1 next cycle; back_tgl 0->1 at the same edge.
- DEPTH=2, b_en with 0x11 then 0x22, bready=0 -> bcount=2, back_tgl toggles once only, ack_pending set. Assert bready one cycle -> bdata=0x11 popped, back_tgl toggles, bdata=0x22.
- Back-to-back: b_en every 4 cycles with 0x01..0x08, bready=1 always -> all 8 words delivered in order, 8 back_tgl edges, bcount never above 1.
- Full plus simultaneous push/pop: count=2 with pending, b_en=0x33 and bready=1 same cycle -> count stays 2, exactly one toggle, ack_pending stays 1, order 0x22,0x33 preserved.
- Overflow: full with no credit, b_en 0x44 and bready=0 -> 0x44 dropped, bcount=2. bovf=1 next cycle with OVF_EN, bovf=0 without.
- Reset mid-operation with bcount=2 -> bvalid=0, bcount=0, back_tgl=0, bovf=0 immediately (asynchronous).
